// File: rtl/aes_job_pkg.sv
// Shared definitions for the AES job master: peripheral register map,
// register bit positions, FSM state encoding and the bus beat record.
package aes_job_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h20;
    localparam logic [7:0] ADDR_STATUS  = 8'h24;
    localparam logic [7:0] ADDR_CONFIG  = 8'h28;
    localparam logic [7:0] ADDR_KEY0    = 8'h40;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h80;
    localparam logic [7:0] ADDR_RESULT0 = 8'hC0;

    localparam int CTRL_START   = 0;
    localparam int STATUS_READY = 0;
    localparam int STATUS_VALID = 1;
    localparam int CFG_ENCDEC   = 0;
    localparam int CFG_KEYLEN   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_CFG = 3'd1,
        ST_WR_KEY = 3'd2,
        ST_WR_BLK = 3'd3,
        ST_START  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_RD_RES = 3'd6,
        ST_DONE   = 3'd7
    } aes_job_state_t;

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } aes_bus_t;

endpackage

// File: rtl/aes_job_master.sv
// Bus initiator that runs one complete AES job (config, key, block, start,
// completion wait, result reads) on the register-slave peripheral.
module aes_job_master
    import aes_job_pkg::*;
#(
    parameter bit          USE_IRQ        = 1'b1,
    parameter int unsigned POLL_GUARD     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic         job_encdec,
    input  logic         job_keylen,
    input  logic         job_key_load,
    input  logic [255:0] job_key,
    input  logic [127:0] job_block,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_error,
    output logic         aes_cs,
    output logic         aes_we,
    output logic [7:0]   aes_address,
    output logic [31:0]  aes_write_data,
    input  logic [31:0]  aes_read_data,
    input  logic         aes_irq,
    output logic         busy
);

    aes_job_state_t state_q, state_d;
    logic [2:0]     wcnt_q, wcnt_d;
    logic [31:0]    tmo_q, tmo_d;
    logic           encdec_q, encdec_d;
    logic           keylen_q, keylen_d;
    logic           key_load_q, key_load_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   res_data_q, res_data_d;
    logic           res_error_q, res_error_d;
    aes_bus_t       bus_q, bus_d;
    logic           job_ready_q, job_ready_d;
    logic           busy_q, busy_d;
    logic           res_valid_q, res_valid_d;
    logic           done_evt_s;
    logic           tmo_hit_s;

    // Bus beat for a given (next) state; registering its result keeps the
    // bus outputs glitch-free while they still line up with the state.
    function automatic aes_bus_t bus_decode(
        input aes_job_state_t st,
        input logic [2:0]     wcnt,
        input logic [31:0]    tmo,
        input logic           encdec,
        input logic           keylen,
        input logic [255:0]   key,
        input logic [127:0]   block
    );
        aes_bus_t b;
        b = '{cs: 1'b0, we: 1'b0, addr: 8'h00, wdata: 32'h0000_0000};
        case (st)
            ST_WR_CFG: begin
                b.cs               = 1'b1;
                b.we               = 1'b1;
                b.addr             = ADDR_CONFIG;
                b.wdata[CFG_ENCDEC] = encdec;
                b.wdata[CFG_KEYLEN] = keylen;
            end
            ST_WR_KEY: begin
                b.cs    = 1'b1;
                b.we    = 1'b1;
                b.addr  = ADDR_KEY0 + {3'b000, wcnt, 2'b00};
                b.wdata = key[{3'd7 - wcnt, 5'd0} +: 32];
            end
            ST_WR_BLK: begin
                b.cs    = 1'b1;
                b.we    = 1'b1;
                b.addr  = ADDR_BLOCK0 + {4'b0000, wcnt[1:0], 2'b00};
                b.wdata = block[{2'd3 - wcnt[1:0], 5'd0} +: 32];
            end
            ST_START: begin
                b.cs               = 1'b1;
                b.we               = 1'b1;
                b.addr             = ADDR_CTRL;
                b.wdata[CTRL_START] = 1'b1;
            end
            ST_WAIT: begin
                if (!USE_IRQ && (tmo >= 32'(POLL_GUARD))) begin
                    b.cs   = 1'b1;
                    b.addr = ADDR_STATUS;
                end else begin
                    b.cs = 1'b0;
                end
            end
            ST_RD_RES: begin
                b.cs   = 1'b1;
                b.addr = ADDR_RESULT0 + {4'b0000, wcnt[1:0], 2'b00};
            end
            default: begin
                b.cs = 1'b0;
            end
        endcase
        return b;
    endfunction

    // Completion and timeout qualifiers for the WAIT state.
    always_comb begin
        if (USE_IRQ) begin
            done_evt_s = aes_irq;
        end else begin
            done_evt_s = bus_q.cs && !bus_q.we && (bus_q.addr == ADDR_STATUS) &&
                         aes_read_data[STATUS_READY] && aes_read_data[STATUS_VALID];
        end
        tmo_hit_s = (TIMEOUT_CYCLES != 0) && ((tmo_q + 32'd1) == 32'(TIMEOUT_CYCLES));
    end

    // Next-state, counters, job capture, result assembly and next outputs.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tmo_d       = tmo_q;
        encdec_d    = encdec_q;
        keylen_d    = keylen_q;
        key_load_d  = key_load_q;
        key_d       = key_q;
        block_d     = block_q;
        res_data_d  = res_data_q;
        res_error_d = res_error_q;

        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    encdec_d    = job_encdec;
                    keylen_d    = job_keylen;
                    key_load_d  = job_key_load;
                    key_d       = job_key;
                    block_d     = job_block;
                    res_error_d = 1'b0;
                    wcnt_d      = 3'd0;
                    state_d     = ST_WR_CFG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_CFG: begin
                wcnt_d  = 3'd0;
                state_d = key_load_q ? ST_WR_KEY : ST_WR_BLK;
            end
            ST_WR_KEY: begin
                if (wcnt_q == 3'd7) begin
                    wcnt_d  = 3'd0;
                    state_d = ST_WR_BLK;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_WR_BLK: begin
                if (wcnt_q == 3'd3) begin
                    wcnt_d  = 3'd0;
                    state_d = ST_START;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_START: begin
                tmo_d   = 32'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (done_evt_s) begin
                    wcnt_d  = 3'd0;
                    state_d = ST_RD_RES;
                end else if (tmo_hit_s) begin
                    res_error_d = 1'b1;
                    res_data_d  = 128'd0;
                    state_d     = ST_DONE;
                end else if (tmo_q != 32'hFFFF_FFFF) begin
                    tmo_d = tmo_q + 32'd1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            ST_RD_RES: begin
                res_data_d = {res_data_q[95:0], aes_read_data};
                if (wcnt_q == 3'd3) begin
                    wcnt_d  = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus_d       = bus_decode(state_d, wcnt_d, tmo_d, encdec_d, keylen_d, key_d, block_d);
        job_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 3'd0;
            tmo_q       <= 32'd0;
            encdec_q    <= 1'b0;
            keylen_q    <= 1'b0;
            key_load_q  <= 1'b0;
            key_q       <= 256'd0;
            block_q     <= 128'd0;
            res_data_q  <= 128'd0;
            res_error_q <= 1'b0;
            bus_q       <= '{cs: 1'b0, we: 1'b0, addr: 8'h00, wdata: 32'h0000_0000};
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tmo_q       <= tmo_d;
            encdec_q    <= encdec_d;
            keylen_q    <= keylen_d;
            key_load_q  <= key_load_d;
            key_q       <= key_d;
            block_q     <= block_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
            bus_q       <= bus_d;
            job_ready_q <= job_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign job_ready      = job_ready_q;
    assign busy           = busy_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_error      = res_error_q;
    assign aes_cs         = bus_q.cs;
    assign aes_we         = bus_q.we;
    assign aes_address    = bus_q.addr;
    assign aes_write_data = bus_q.wdata;

endmodule

// File: tb/tb_aes_job_master.sv
// Bench for aes_job_master: an irq-mode instance (timeout 16) and a polling
// instance, each driving a behavioural AES register-slave stub.
module tb_aes_job_master;
    import aes_job_pkg::*;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam int           GUARD = 2;

    typedef struct {
        int           inst;
        logic         encdec;
        logic         keylen;
        logic         key_load;
        logic [255:0] key;
        logic [127:0] block;
        bit           irq_en;
        bit           exp_err;
        int           hold;
        logic [127:0] exp_res;
    } job_vec_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } res_exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic         job_valid_s[2], job_ready_s[2], job_encdec_s[2], job_keylen_s[2], job_key_load_s[2];
    logic [255:0] job_key_s[2];
    logic [127:0] job_block_s[2], res_data_s[2];
    logic         res_valid_s[2], res_ready_s[2], res_error_s[2];
    logic         cs_s[2], we_s[2], irq_s[2], busy_s[2];
    logic [7:0]   addr_s[2];
    logic [31:0]  wdata_s[2], rdata_s[2];

    aes_job_master #(.USE_IRQ(1'b1), .POLL_GUARD(GUARD), .TIMEOUT_CYCLES(16)) u_irq (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid_s[0]), .job_ready(job_ready_s[0]), .job_encdec(job_encdec_s[0]),
        .job_keylen(job_keylen_s[0]), .job_key_load(job_key_load_s[0]), .job_key(job_key_s[0]),
        .job_block(job_block_s[0]), .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0]),
        .res_data(res_data_s[0]), .res_error(res_error_s[0]), .aes_cs(cs_s[0]), .aes_we(we_s[0]),
        .aes_address(addr_s[0]), .aes_write_data(wdata_s[0]), .aes_read_data(rdata_s[0]),
        .aes_irq(irq_s[0]), .busy(busy_s[0])
    );

    aes_job_master #(.USE_IRQ(1'b0), .POLL_GUARD(GUARD), .TIMEOUT_CYCLES(4096)) u_poll (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid_s[1]), .job_ready(job_ready_s[1]), .job_encdec(job_encdec_s[1]),
        .job_keylen(job_keylen_s[1]), .job_key_load(job_key_load_s[1]), .job_key(job_key_s[1]),
        .job_block(job_block_s[1]), .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1]),
        .res_data(res_data_s[1]), .res_error(res_error_s[1]), .aes_cs(cs_s[1]), .aes_we(we_s[1]),
        .aes_address(addr_s[1]), .aes_write_data(wdata_s[1]), .aes_read_data(rdata_s[1]),
        .aes_irq(irq_s[1]), .busy(busy_s[1])
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int start_cyc[2];
    bit poll_seen[2];
    bit irq_en[2];
    bus_exp_t bq0[$], bq1[$];
    res_exp_t rq0[$], rq1[$];

    // Peripheral model: known FIPS-197 vectors, otherwise a simple keyed mix.
    function automatic logic [127:0] aes_model(input logic [255:0] key, input logic [127:0] blk,
                                               input logic [1:0] cfg);
        if (key == K128 && cfg == 2'b01 && blk == PT)   return C128;
        if (key == K128 && cfg == 2'b00 && blk == C128) return PT;
        if (key == K256 && cfg == 2'b11 && blk == PT)   return C256;
        if (key == K256 && cfg == 2'b10 && blk == C256) return PT;
        return blk ^ key[255:128] ^ key[127:0] ^ {126'd0, cfg};
    endfunction

    logic [255:0] skey_r[2];
    logic [127:0] sblk_r[2];
    logic [1:0]   scfg_r[2];
    logic         sbusy_r[2], sdone_r[2], sirq_r[2];
    int           scnt_r[2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            sirq_r[i] <= 1'b0;
            if (cs_s[i] && we_s[i] && addr_s[i] == ADDR_CONFIG) scfg_r[i] <= wdata_s[i][1:0];
            if (cs_s[i] && we_s[i] && addr_s[i][7:5] == 3'b010)
                skey_r[i][(7 - int'(addr_s[i][4:2])) * 32 +: 32] <= wdata_s[i];
            if (cs_s[i] && we_s[i] && addr_s[i][7:4] == 4'h8)
                sblk_r[i][(3 - int'(addr_s[i][3:2])) * 32 +: 32] <= wdata_s[i];
            if (cs_s[i] && we_s[i] && addr_s[i] == ADDR_CTRL && wdata_s[i][0]) begin
                sbusy_r[i] <= 1'b1;
                sdone_r[i] <= 1'b0;
                scnt_r[i]  <= 4;
            end else if (sbusy_r[i]) begin
                if (scnt_r[i] <= 1) begin
                    sbusy_r[i] <= 1'b0;
                    sdone_r[i] <= 1'b1;
                    sirq_r[i]  <= irq_en[i];
                end else begin
                    scnt_r[i] <= scnt_r[i] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic [127:0] r;
            r = aes_model(skey_r[i], sblk_r[i], scfg_r[i]);
            irq_s[i]   = sirq_r[i];
            rdata_s[i] = 32'd0;
            if (cs_s[i] && !we_s[i]) begin
                if (addr_s[i] == ADDR_STATUS) rdata_s[i] = {30'd0, sdone_r[i], !sbusy_r[i]};
                else if (addr_s[i][7:4] == 4'hC) rdata_s[i] = r[(3 - int'(addr_s[i][3:2])) * 32 +: 32];
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input int i, input logic we, input logic [7:0] a, input logic [31:0] d);
        bus_exp_t e;
        e = '{we, a, d};
        if (i == 0) bq0.push_back(e); else bq1.push_back(e);
    endtask

    task automatic push_job(input job_vec_t v);
        res_exp_t r;
        push_bus(v.inst, 1'b1, ADDR_CONFIG, {30'd0, v.keylen, v.encdec});
        if (v.key_load)
            for (int k = 0; k < 8; k++) push_bus(v.inst, 1'b1, 8'(8'h40 + 4 * k), v.key[(7 - k) * 32 +: 32]);
        for (int k = 0; k < 4; k++) push_bus(v.inst, 1'b1, 8'(8'h80 + 4 * k), v.block[(3 - k) * 32 +: 32]);
        push_bus(v.inst, 1'b1, ADDR_CTRL, 32'd1);
        if (!v.exp_err)
            for (int k = 0; k < 4; k++) push_bus(v.inst, 1'b0, 8'(8'hC0 + 4 * k), 32'd0);
        r.data = v.exp_err ? 128'd0 : v.exp_res;
        r.err  = v.exp_err;
        if (v.inst == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic monitor(input int i);
        bus_exp_t e;
        res_exp_t r;
        bit       empty;
        if (cs_s[i]) begin
            if (i == 1 && !we_s[i] && addr_s[i] == ADDR_STATUS) begin
                if (!poll_seen[i]) begin
                    check("poll_guard", 256'(cyc - start_cyc[i] > GUARD), 256'd1);
                    poll_seen[i] = 1'b1;
                end
            end else begin
                empty = (i == 0) ? (bq0.size() == 0) : (bq1.size() == 0);
                if (empty) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_access inst%0d: got we=%b addr=%h data=%h required none",
                             i, we_s[i], addr_s[i], wdata_s[i]);
                end else begin
                    e = (i == 0) ? bq0.pop_front() : bq1.pop_front();
                    check("bus_we", 256'(we_s[i]), 256'(e.we));
                    check("bus_addr", 256'(addr_s[i]), 256'(e.addr));
                    if (e.we) check("bus_wdata", 256'(wdata_s[i]), 256'(e.data));
                end
                if (we_s[i] && addr_s[i] == ADDR_CTRL) begin
                    start_cyc[i] = cyc;
                    poll_seen[i] = 1'b0;
                end
            end
        end else if (we_s[i] || addr_s[i] != 8'd0 || wdata_s[i] != 32'd0) begin
            check("bus_idle_zero", {215'd0, we_s[i], addr_s[i], wdata_s[i]}, 256'd0);
        end
        if (res_valid_s[i] && res_ready_s[i]) begin
            empty = (i == 0) ? (rq0.size() == 0) : (rq1.size() == 0);
            if (empty) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_result inst%0d: got %h required none", i, res_data_s[i]);
            end else begin
                r = (i == 0) ? rq0.pop_front() : rq1.pop_front();
                check("res_data", 256'(res_data_s[i]), 256'(r.data));
                check("res_error", 256'(res_error_s[i]), 256'(r.err));
            end
        end
    endtask

    always @(negedge clk) if (reset_n) begin
        monitor(0);
        monitor(1);
    end

    task automatic offer(input job_vec_t v);
        int n;
        @(posedge clk); #1;
        job_encdec_s[v.inst]   = v.encdec;
        job_keylen_s[v.inst]   = v.keylen;
        job_key_load_s[v.inst] = v.key_load;
        job_key_s[v.inst]      = v.key;
        job_block_s[v.inst]    = v.block;
        job_valid_s[v.inst]    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!job_ready_s[v.inst] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 256'(job_ready_s[v.inst]), 256'd1);
        @(posedge clk); #1;
        job_valid_s[v.inst] = 1'b0;
    endtask

    task automatic run_job(input job_vec_t v);
        int           n;
        int           i;
        logic [127:0] d0;
        i = v.inst;
        irq_en[i] = v.irq_en;
        res_ready_s[i] = (v.hold == 0);
        push_job(v);
        offer(v);
        n = 0;
        while (!res_valid_s[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", 256'(res_valid_s[i]), 256'd1);
        if (v.exp_err) check("timeout_latency", 256'(cyc - start_cyc[i]), 256'd17);
        if (v.hold > 0) begin
            d0 = res_data_s[i];
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                check("hold_valid", 256'(res_valid_s[i]), 256'd1);
                check("hold_data", 256'(res_data_s[i]), 256'(d0));
                check("hold_job_ready", 256'(job_ready_s[i]), 256'd0);
            end
            @(posedge clk); #1;
            res_ready_s[i] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("release_idle_ready", 256'(job_ready_s[i]), 256'd1);
            check("release_res_valid", 256'(res_valid_s[i]), 256'd0);
        end else begin
            @(negedge clk);
            @(negedge clk);
        end
        check("res_queue_drained", 256'((i == 0) ? rq0.size() : rq1.size()), 256'd0);
        check("bus_queue_drained", 256'((i == 0) ? bq0.size() : bq1.size()), 256'd0);
    endtask

    job_vec_t tbl[6];

    initial begin
        logic [255:0] fkey;
        logic [127:0] fblk;
        int           n;
        fkey = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0_1122334455667788_99aabbccddeeff00;
        fblk = 128'hcafef00d_12345678_deadbeef_a5a55a5a;
        tbl[0] = '{0, 1'b1, 1'b0, 1'b1, K128, PT,   1'b1, 1'b0, 0,  C128};
        tbl[1] = '{0, 1'b1, 1'b1, 1'b1, K256, PT,   1'b1, 1'b0, 0,  C256};
        tbl[2] = '{0, 1'b0, 1'b1, 1'b0, 256'd0, C256, 1'b1, 1'b0, 0, PT};
        tbl[3] = '{1, 1'b1, 1'b0, 1'b1, K128, PT,   1'b0, 1'b0, 0,  C128};
        tbl[4] = '{0, 1'b1, 1'b0, 1'b1, fkey, fblk, 1'b1, 1'b0, 20, aes_model(fkey, fblk, 2'b01)};
        tbl[5] = '{0, 1'b1, 1'b0, 1'b1, K128, PT,   1'b0, 1'b1, 0,  128'd0};

        for (int i = 0; i < 2; i++) begin
            job_valid_s[i] = 1'b0; job_encdec_s[i] = 1'b0; job_keylen_s[i] = 1'b0;
            job_key_load_s[i] = 1'b0; job_key_s[i] = 256'd0; job_block_s[i] = 128'd0;
            res_ready_s[i] = 1'b1; irq_en[i] = 1'b0; start_cyc[i] = 0; poll_seen[i] = 1'b0;
            sbusy_r[i] = 1'b0; sdone_r[i] = 1'b0; scnt_r[i] = 0; skey_r[i] = 256'd0;
            sblk_r[i] = 128'd0; scfg_r[i] = 2'd0;
        end
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_job_ready", 256'(job_ready_s[0]), 256'd1);
        check("rst_busy", 256'(busy_s[0]), 256'd0);
        check("rst_res_valid", 256'(res_valid_s[0]), 256'd0);
        check("rst_bus", {215'd0, cs_s[0], we_s[0], addr_s[0], wdata_s[0]}, 256'd0);
        check("rst_res", {127'd0, res_error_s[1], res_data_s[1]}, 256'd0);
        reset_n = 1'b1;

        for (int t = 0; t < 6; t++) run_job(tbl[t]);

        // Reset while the third block word is on the bus.
        irq_en[0] = 1'b1;
        push_job(tbl[0]);
        offer(tbl[0]);
        n = 0;
        while (!(cs_s[0] && addr_s[0] == 8'h88) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reached_blk2", 256'(addr_s[0]), 256'(8'h88));
        #2 reset_n = 1'b0;
        #1;
        check("midrst_bus", {215'd0, cs_s[0], we_s[0], addr_s[0], wdata_s[0]}, 256'd0);
        check("midrst_job_ready", 256'(job_ready_s[0]), 256'd1);
        check("midrst_busy", 256'(busy_s[0]), 256'd0);
        bq0.delete();
        rq0.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_job(tbl[0]);
        run_job(tbl[3]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
